// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between requester ports, the ROM port arbiter and one
// SDRAM channel.
interface rom_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 25
);
    logic [NUM_REQ-1:0]        req_tog;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        ack_tog;
    logic [63:0]               rd_data;
    logic [ADDR_W-1:0]         sdr_addr;
    logic                      sdr_req;
    logic [63:0]               sdr_data;
    logic                      sdr_rdy;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  req_tog, req_addr, sdr_data, sdr_rdy,
        output ack_tog, rd_data, sdr_addr, sdr_req, busy, timeout_err
    );

    modport slave (
        output req_tog, req_addr, sdr_data, sdr_rdy,
        input  ack_tog, rd_data, sdr_addr, sdr_req, busy, timeout_err
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM read channel between
// toggle-handshake requester ports, with re-issue on timeout.
module rom_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic                clk_ram,
    input  logic                reset,
    rom_port_arbiter_if.master  bus
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] sync1;
    logic [NUM_REQ-1:0] sync2;
    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] ack_q;
    logic [GW-1:0]      grant;
    logic [GW-1:0]      last_grant;
    logic [GW-1:0]      pick;
    logic               found;
    logic [7:0]         timer;
    logic               timed_out;
    logic [63:0]        rd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               req_q;
    logic               err_q;
    logic               busy_c;

    assign pending   = sync2 ^ ack_q;
    assign timed_out = (timer == 8'(TIMEOUT - 1));

    assign bus.ack_tog     = ack_q;
    assign bus.rd_data     = rd_q;
    assign bus.sdr_addr    = addr_q;
    assign bus.sdr_req     = req_q;
    assign bus.timeout_err = err_q;
    assign bus.busy        = busy_c;

    // Two-flop synchronizer for the asynchronous request toggles
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.req_tog;
            sync2 <= sync1;
        end
    end

    // Round-robin search for the first pending port after last_grant
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = last_grant;
        idx   = 0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            idx = int'(last_grant) + o;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && pending[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_ram) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (found) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (bus.sdr_rdy)    state_nxt = IDLE;
                else if (timed_out) state_nxt = ISSUE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs decoded from state
    always_comb begin
        busy_c = (state != IDLE);
    end

    // Grant, SDRAM request, timer and completion datapath
    always_ff @(posedge clk_ram) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            addr_q     <= '0;
            req_q      <= 1'b0;
            timer      <= '0;
            rd_q       <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            req_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) grant <= pick;
                end
                ISSUE: begin
                    addr_q <= bus.req_addr[int'(grant)*ADDR_W +: ADDR_W];
                    req_q  <= 1'b1;
                    timer  <= '0;
                end
                WAIT: begin
                    if (bus.sdr_rdy) begin
                        rd_q         <= bus.sdr_data;
                        ack_q[grant] <= ~ack_q[grant];
                        last_grant   <= grant;
                    end else if (timed_out) begin
                        err_q <= 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
